// File: rtl/naive_bus_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : naive_bus_rr_arbiter_if
// Description : Naive-bus bundle between NM masters, the arbiter and one slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface naive_bus_rr_arbiter_if #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32
);
    // Master side, packed per master (master i at slice i)
    logic [NM-1:0]          m_rd_req;
    logic [NM-1:0]          m_wr_req;
    logic [NM*AW-1:0]       m_addr;
    logic [NM*DW-1:0]       m_wr_data;
    logic [NM*(DW/8)-1:0]   m_wr_be;
    logic [NM-1:0]          m_rd_gnt;
    logic [NM-1:0]          m_wr_gnt;
    logic [DW-1:0]          m_rd_data;
    logic [NM-1:0]          m_rd_vld;

    // Slave side
    logic                   s_rd_req;
    logic                   s_wr_req;
    logic [AW-1:0]          s_addr;
    logic [DW-1:0]          s_wr_data;
    logic [DW/8-1:0]        s_wr_be;
    logic                   s_rd_gnt;
    logic                   s_wr_gnt;
    logic [DW-1:0]          s_rd_data;

    modport master (
        output m_rd_req, m_wr_req, m_addr, m_wr_data, m_wr_be,
        input  m_rd_gnt, m_wr_gnt, m_rd_data, m_rd_vld
    );

    modport slave (
        input  s_rd_req, s_wr_req, s_addr, s_wr_data, s_wr_be,
        output s_rd_gnt, s_wr_gnt, s_rd_data
    );

    modport arb (
        input  m_rd_req, m_wr_req, m_addr, m_wr_data, m_wr_be,
        output m_rd_gnt, m_wr_gnt, m_rd_data, m_rd_vld,
        output s_rd_req, s_wr_req, s_addr, s_wr_data, s_wr_be,
        input  s_rd_gnt, s_wr_gnt, s_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/naive_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : naive_bus_rr_arbiter
// Description : Round-robin arbiter sharing one naive-bus slave among NM
//               masters, with debugger hold and starvation detection.
// Revision    : 1.0 - initial release
// ============================================================================
module naive_bus_rr_arbiter #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dbg_hold,
    output logic                    starve_flag,
    naive_bus_rr_arbiter_if.arb     bus
);

    localparam int              c_ptr_w        = $clog2(NM);
    localparam int              c_bw           = DW / 8;
    localparam logic [7:0]      c_starve_limit = 8'd255;
    localparam logic [NM-1:0]   c_one          = NM'(1);

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] r_rd_owner;
    logic               r_rd_pend;
    logic               r_starve;

    logic [NM-1:0]      w_elig;
    logic [NM-1:0]      w_starved;
    logic [NM-1:0]      w_owner_oh;
    logic [c_ptr_w-1:0] w_owner;
    logic [c_ptr_w-1:0] w_ptr_next;
    logic               w_any;
    logic               w_grant;
    logic               w_rd_grant;

    // Eligibility and per-master wait counters
    for (genvar i = 0; i < NM; i++) begin : g_master
        logic [7:0] r_wait;

        assign w_elig[i] = (bus.m_rd_req[i] | bus.m_wr_req[i]) & (~dbg_hold | (i == 0));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wait <= '0;
            end else if (!w_elig[i] || (w_grant && w_owner_oh[i])) begin
                r_wait <= '0;
            end else if (r_wait != c_starve_limit) begin
                r_wait <= r_wait + 8'd1;
            end
        end

        assign w_starved[i] = (r_wait == c_starve_limit);
    end

    // First eligible master at or after r_ptr; walking k downward lets the
    // nearest candidate overwrite the farther ones.
    always_comb begin
        int idx;
        w_owner = '0;
        w_any   = 1'b0;
        idx     = 0;
        for (int k = NM - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NM;
            if (w_elig[idx]) begin
                w_owner = c_ptr_w'(idx);
                w_any   = 1'b1;
            end
        end
    end

    assign w_owner_oh = w_any ? (c_one << w_owner) : '0;
    assign w_rd_grant = w_any & bus.s_rd_gnt;
    assign w_grant    = w_any & (bus.s_rd_gnt | bus.s_wr_gnt);
    assign w_ptr_next = (int'(w_owner) == NM - 1) ? '0 : w_owner + 1'b1;

    // Owner's request passes straight through; idle bus drives zeros
    always_comb begin
        bus.s_rd_req  = 1'b0;
        bus.s_wr_req  = 1'b0;
        bus.s_addr    = '0;
        bus.s_wr_data = '0;
        bus.s_wr_be   = '0;
        if (w_any) begin
            bus.s_rd_req  = bus.m_rd_req[w_owner];
            bus.s_wr_req  = bus.m_wr_req[w_owner];
            bus.s_addr    = bus.m_addr[w_owner*AW +: AW];
            bus.s_wr_data = bus.m_wr_data[w_owner*DW +: DW];
            bus.s_wr_be   = bus.m_wr_be[w_owner*c_bw +: c_bw];
        end
    end

    assign bus.m_rd_gnt  = {NM{bus.s_rd_gnt}} & w_owner_oh;
    assign bus.m_wr_gnt  = {NM{bus.s_wr_gnt}} & w_owner_oh;
    assign bus.m_rd_data = bus.s_rd_data;
    // Reset also masks the flag of a read whose data was due this cycle
    assign bus.m_rd_vld  = (r_rd_pend && !rst) ? (c_one << r_rd_owner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= '0;
            r_starve   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ptr <= w_ptr_next;
            end
            r_rd_pend <= w_rd_grant;
            if (w_rd_grant) begin
                r_rd_owner <= w_owner;
            end
            if (|w_starved) begin
                r_starve <= 1'b1;
            end
        end
    end

    assign starve_flag = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_naive_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_naive_bus_rr_arbiter
// Description : Directed self-checking bench for naive_bus_rr_arbiter (NM=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_naive_bus_rr_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_hold = 1'b0;
    logic starve_flag;

    int checks = 0;
    int errors = 0;

    naive_bus_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

    naive_bus_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .dbg_hold    (dbg_hold),
        .starve_flag (starve_flag),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
        bus.m_rd_req[i]          = rd;
        bus.m_wr_req[i]          = wr;
        bus.m_addr[i*AW +: AW]   = addr;
        bus.m_wr_data[i*DW +: DW] = data;
        bus.m_wr_be[i*4 +: 4]    = be;
    endtask

    task automatic clear_all();
        bus.m_rd_req  = '0;
        bus.m_wr_req  = '0;
        bus.m_addr    = '0;
        bus.m_wr_data = '0;
        bus.m_wr_be   = '0;
        bus.s_rd_gnt  = 1'b0;
        bus.s_wr_gnt  = 1'b0;
    endtask

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h1000_0100;
    localparam logic [31:0] A2 = 32'h1000_0200;

    initial begin
        logic [2:0] exp_oh;
        clear_all();
        bus.s_rd_data = '0;

        // ---------------- reset then idle ----------------
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("idle_s_req", {62'd0, bus.s_rd_req, bus.s_wr_req}, 64'd0);
            check_eq("idle_s_addr", {32'd0, bus.s_addr}, 64'd0);
            check_eq("idle_rd_vld", {61'd0, bus.m_rd_vld}, 64'd0);
            check_eq("idle_starve", {63'd0, starve_flag}, 64'd0);
        end

        // ---------------- round robin, ptr starts at 0 ----------------
        set_req(0, 1'b1, 1'b0, A0, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, A1, 32'h0, 4'h0);
        set_req(2, 1'b1, 1'b0, A2, 32'h0, 4'h0);
        bus.s_rd_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.s_rd_data = 32'h100 + c;
            #1;
            exp_oh = 3'b001 << (c % 3);
            check_eq("rr_gnt", {61'd0, bus.m_rd_gnt}, {61'd0, exp_oh});
            check_eq("rr_addr", {32'd0, bus.s_addr}, {32'd0, (c % 3 == 0) ? A0 : (c % 3 == 1) ? A1 : A2});
            exp_oh = (c == 0) ? 3'b000 : (3'b001 << ((c - 1) % 3));
            check_eq("rr_vld", {61'd0, bus.m_rd_vld}, {61'd0, exp_oh});
            check_eq("rr_data", {32'd0, bus.m_rd_data}, 64'h100 + c);
            tick();
        end
        clear_all();
        #1;
        check_eq("rr_vld_tail", {61'd0, bus.m_rd_vld}, 64'b100);
        tick();
        check_eq("rr_vld_off", {61'd0, bus.m_rd_vld}, 64'd0);

        // ---------------- slave stall: move ptr to 1 first ----------------
        set_req(0, 1'b1, 1'b0, A0, 32'h0, 4'h0);
        bus.s_rd_gnt = 1'b1;
        tick();
        clear_all();
        set_req(1, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
        set_req(2, 1'b1, 1'b0, A2, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("stall_addr", {32'd0, bus.s_addr}, 64'h2000);
            check_eq("stall_req", {62'd0, bus.s_rd_req, bus.s_wr_req}, 64'b01);
            check_eq("stall_wgnt", {61'd0, bus.m_wr_gnt}, 64'd0);
            tick();
        end
        check_eq("stall_wdata", {32'd0, bus.s_wr_data}, 64'hDEAD_BEEF);
        check_eq("stall_be", {60'd0, bus.s_wr_be}, 64'hF);
        bus.s_wr_gnt = 1'b1;
        #1;
        check_eq("stall_wgnt_on", {61'd0, bus.m_wr_gnt}, 64'b010);
        check_eq("stall_rgnt_off", {61'd0, bus.m_rd_gnt}, 64'd0);
        tick();
        bus.s_wr_gnt = 1'b0;
        #1;
        check_eq("stall_next_owner", {32'd0, bus.s_addr}, {32'd0, A2});
        check_eq("stall_next_req", {62'd0, bus.s_rd_req, bus.s_wr_req}, 64'b10);
        bus.s_rd_gnt = 1'b1;
        #1;
        check_eq("stall_m2_gnt", {61'd0, bus.m_rd_gnt}, 64'b100);
        tick();
        clear_all();
        #1;
        check_eq("stall_m2_vld", {61'd0, bus.m_rd_vld}, 64'b100);
        tick();

        // ---------------- debugger hold (ptr = 0) ----------------
        dbg_hold = 1'b1;
        set_req(1, 1'b1, 1'b0, A1, 32'h0, 4'h0);
        set_req(2, 1'b1, 1'b0, A2, 32'h0, 4'h0);
        for (int c = 0; c < 2; c++) begin
            #1;
            check_eq("hold_no_req", {62'd0, bus.s_rd_req, bus.s_wr_req}, 64'd0);
            check_eq("hold_addr", {32'd0, bus.s_addr}, 64'd0);
            tick();
        end
        set_req(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
        bus.s_rd_gnt = 1'b1;
        #1;
        check_eq("hold_dbg_addr", {32'd0, bus.s_addr}, 64'h4);
        check_eq("hold_dbg_gnt", {61'd0, bus.m_rd_gnt}, 64'b001);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        dbg_hold = 1'b0;
        #1;
        check_eq("hold_rel_gnt1", {61'd0, bus.m_rd_gnt}, 64'b010);
        check_eq("hold_rel_vld0", {61'd0, bus.m_rd_vld}, 64'b001);
        tick();
        check_eq("hold_rel_gnt2", {61'd0, bus.m_rd_gnt}, 64'b100);
        check_eq("hold_rel_vld1", {61'd0, bus.m_rd_vld}, 64'b010);
        tick();
        clear_all();
        tick();

        // ---------------- reset mid-read (ptr = 0) ----------------
        set_req(2, 1'b1, 1'b0, A2, 32'h0, 4'h0);
        bus.s_rd_gnt = 1'b1;
        #1;
        check_eq("rst_m2_gnt", {61'd0, bus.m_rd_gnt}, 64'b100);
        tick();
        // Grant master 1 during reset: without reset ptr would move to 2
        rst = 1'b1;
        set_req(2, 1'b0, 1'b0, A2, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, A1, 32'h0, 4'h0);
        #1;
        check_eq("rst_vld_drop", {61'd0, bus.m_rd_vld}, 64'd0);
        tick();
        rst = 1'b0;
        clear_all();
        #1;
        check_eq("rst_vld_after", {61'd0, bus.m_rd_vld}, 64'd0);
        set_req(0, 1'b1, 1'b0, A0, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, A1, 32'h0, 4'h0);
        set_req(2, 1'b1, 1'b0, A2, 32'h0, 4'h0);
        #1;
        check_eq("rst_ptr_zero", {32'd0, bus.s_addr}, {32'd0, A0});
        tick();
        clear_all();
        tick();

        // ---------------- starvation: slave grants only master 0 ----------------
        set_req(0, 1'b1, 1'b0, A0, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, A1, 32'h0, 4'h0);
        for (int n = 0; n < 300; n++) begin
            #1;
            bus.s_rd_gnt = (bus.s_addr == A0);
            #1;
            if (n == 200) check_eq("starve_early", {63'd0, starve_flag}, 64'd0);
            tick();
        end
        check_eq("starve_set", {63'd0, starve_flag}, 64'd1);
        clear_all();
        for (int c = 0; c < 5; c++) tick();
        check_eq("starve_sticky", {63'd0, starve_flag}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("starve_cleared", {63'd0, starve_flag}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
